gen_stream_collector: RTL and testbench
=======================================

Name: gen_stream_collector

Overview:
- Caller-side (initiator) engine for the generator ready/valid/done protocol.
- Launches a two-output generator module with three signed arguments, consumes every yielded tuple under backpressure, and buffers the tuples in a FIFO for a downstream ready/valid sink.
- Reports tuple count, completion and timeout status.
- Sits between control logic and any generated producer module (e.g. hrange).

Parameters:
- WIDTH, 32, bit width of arguments and tuple elements (signed).
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 1024, COLLECT cycles without gen_valid or gen_done before error; 0 disables the timeout.
- CNT_W, 16, width of tuple counter.

Ports:
- _clock  in  1  system clock, rising edge.
- _reset  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle request to launch a run; honoured only in IDLE, DONE or ERROR.
- arg0, arg1, arg2  in  WIDTH each  generator arguments; sampled when cmd_start is accepted.
- gen_start  out  1  to generator _start.
- gen_base, gen_limit, gen_step  out  WIDTH each  to generator arguments.
- gen_ready  out  1  to generator _ready.
- gen_valid  in  1  from generator _valid.
- gen_done  in  1  from generator _done.
- gen_out0, gen_out1  in  WIDTH each  generator tuple.
- m_valid  out  1  FIFO head valid (first-word fall-through).
- m_ready  in  1  downstream accept.
- m_data0, m_data1  out  WIDTH each  FIFO head tuple.
- busy  out  1  high in LAUNCH, COLLECT and DRAIN.
- run_done  out  1  sticky high in DONE.
- run_err  out  1  sticky high in ERROR.
- tuple_count  out  CNT_W  tuples accepted in the current or last run; saturates at all-ones.

Behaviour:
- Reset (_reset low, asynchronous):
  - state IDLE; FIFO emptied; tuple_count 0.
  - gen_start, gen_ready, m_valid, busy, run_done, run_err all 0.
  - gen_base, gen_limit, gen_step 0.
  - Reset mid-run aborts with no further FIFO pushes. The generator has its own reset.
- States: IDLE, LAUNCH, COLLECT, DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR + cmd_start:
  - Register args onto gen_base/gen_limit/gen_step.
  - Clear tuple_count, run_done and run_err; FIFO contents are kept.
  - Go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - gen_start=1, gen_ready=0.
  - gen_done and gen_valid are ignored; they are stale from the previous run.
  - Next state COLLECT.
- COLLECT:
  - gen_start=0.
  - gen_ready is combinational: high while FIFO occupancy < DEPTH. No pop-through when full.
  - Transfer: any cycle with gen_valid and gen_ready pushes {gen_out0, gen_out1} and increments tuple_count.
  - gen_done high:
    - If gen_valid is also high and gen_ready is high, push that tuple in the same cycle, then go to DRAIN.
    - If gen_valid is also high but the FIFO is full, stay in COLLECT until the tuple is accepted.
    - Otherwise go to DRAIN.
  - Timeout counter:
    - Clears on gen_valid or gen_done.
    - Increments otherwise, including while the FIFO is full.
    - On reaching TIMEOUT: go to ERROR, gen_ready=0.
- DRAIN: gen_ready=0; wait for the FIFO to empty, then go to DONE.
- DONE: run_done=1, busy=0.
- ERROR: run_err=1, busy=0; remaining FIFO entries can still be popped.
- cmd_start while busy is ignored.
- FIFO:
  - A pop occurs when m_valid and m_ready are both high.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Pointers wrap modulo DEPTH; occupancy register is $clog2(DEPTH)+1 bits.
  - m_data0/m_data1 hold the head entry while m_valid is high.
- Latency:
  - cmd_start to gen_start: 1 cycle.
  - Accepted tuple to m_valid: 1 cycle.

Decomposition:
- Package gen_collect_pkg holds:
  - state enum (IDLE, LAUNCH, COLLECT, DRAIN, DONE, ERROR);
  - tuple struct {data0, data1} of WIDTH each.
- One sub-module, gen_tuple_fifo:
  - parameterised WIDTH/DEPTH;
  - synchronous push/pop;
  - full/empty/occupancy outputs;
  - same async active-low reset.
- The collector FSM, timeout counter and tuple counter live in gen_stream_collector.

Test Plan:
- hrange stub, args (1,11,3), m_ready=1 -> m_data0/m_data1 stream (1,1),(4,4),(7,7),(10,10); tuple_count=4; run_done=1; busy=0.
- Args (5,5,1), empty range -> zero pushes; m_valid never high; tuple_count=0; DRAIN to DONE within 3 cycles of gen_done.
- DEPTH=4, args (0,20,2), m_ready low for 30 cycles then 1 -> gen_ready drops with 4 entries held; all 10 tuples 0,2,...,18 delivered in order, none lost or duplicated.
- Stub asserts gen_valid and gen_done in the same cycle on the last tuple (value 8) -> 8 pushed; count matches; state DRAIN then DONE.
- Stub never asserts valid/done, TIMEOUT=16 -> run_err=1 exactly 16 COLLECT cycles after LAUNCH; gen_ready=0; a new cmd_start clears run_err.
- _reset low for 1 cycle after 2 of 4 tuples -> all outputs return to reset values immediately; FIFO empty; next cmd_start runs a clean 4-tuple sequence.

Source files
------------

// File: rtl/gen_collect_pkg.sv
// Shared types for the generator stream collector.
package gen_collect_pkg;

    localparam int unsigned GEN_WIDTH = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StCollect,
        StDrain,
        StDone,
        StError
    } state_e;

    // One yielded generator tuple at the default element width.
    typedef struct packed {
        logic signed [GEN_WIDTH-1:0] data0;
        logic signed [GEN_WIDTH-1:0] data1;
    } tuple_t;

endpackage

// File: rtl/gen_stream_collector_if.sv
// Generator handshake plus downstream tuple stream, bundled for the collector.
interface gen_stream_collector_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic                    gen_start;
    logic signed [WIDTH-1:0] gen_base;
    logic signed [WIDTH-1:0] gen_limit;
    logic signed [WIDTH-1:0] gen_step;
    logic                    gen_ready;
    logic                    gen_valid;
    logic                    gen_done;
    logic signed [WIDTH-1:0] gen_out0;
    logic signed [WIDTH-1:0] gen_out1;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [WIDTH-1:0] m_data0;
    logic signed [WIDTH-1:0] m_data1;

    // Collector side: drives the generator controls and the downstream stream.
    modport master (
        output gen_start, gen_base, gen_limit, gen_step, gen_ready,
        input  gen_valid, gen_done, gen_out0, gen_out1,
        output m_valid, m_data0, m_data1,
        input  m_ready
    );

    // Environment side: the generator and the downstream sink.
    modport slave (
        input  gen_start, gen_base, gen_limit, gen_step, gen_ready,
        output gen_valid, gen_done, gen_out0, gen_out1,
        input  m_valid, m_data0, m_data1,
        output m_ready
    );

endinterface

// File: rtl/gen_tuple_fifo.sv
// First-word fall-through FIFO holding collected tuples.
module gen_tuple_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   occ_q;
    logic             do_push, do_pop;

    assign full    = (occ_q == (PTR_W+1)'(DEPTH));
    assign empty   = (occ_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

    // Storage array; emptiness is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                occ_q <= occ_q + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                occ_q <= occ_q - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/gen_stream_collector.sv
// Initiator for the generator ready/valid/done protocol: launches a run, collects
// every yielded tuple into a FIFO and reports count, completion and timeout.
module gen_stream_collector
    import gen_collect_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    cmd_start,
    input  logic signed [WIDTH-1:0] arg0,
    input  logic signed [WIDTH-1:0] arg1,
    input  logic signed [WIDTH-1:0] arg2,
    gen_stream_collector_if.master  bus,
    output logic                    busy,
    output logic                    run_done,
    output logic                    run_err,
    output logic [CNT_W-1:0]        tuple_count
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W:0] TMO_LIM = (TMO_W+1)'(TIMEOUT);

    state_e                  state_q, state_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [WIDTH-1:0] base_q, limit_q, step_q;
    logic                    start_run;
    logic                    ready;
    logic                    push;
    logic                    fifo_full, fifo_empty;
    logic [OCC_W-1:0]        fifo_occ;
    logic [2*WIDTH-1:0]      head;

    assign push = ready && bus.gen_valid;

    gen_tuple_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (_clock),
        .rst_n     (_reset),
        .push      (push),
        .push_data ({bus.gen_out0, bus.gen_out1}),
        .pop       (bus.m_valid && bus.m_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    // Next-state, timeout and tuple counting for the run sequencer.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        start_run = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (cmd_start) begin
                    start_run = 1'b1;
                    cnt_d     = '0;
                    state_d   = StLaunch;
                end
            end
            // Generator outputs are stale from the previous run here; ignore them.
            StLaunch: begin
                tmo_d   = '0;
                state_d = StCollect;
            end
            StCollect: begin
                ready = !fifo_full;
                if (bus.gen_valid && ready && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bus.gen_valid || bus.gen_done) begin
                    tmo_d = '0;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (({1'b0, tmo_q} + (TMO_W+1)'(1)) == TMO_LIM) begin
                        state_d = StError;
                    end
                end
                // A final tuple paired with done must be taken before leaving.
                if (bus.gen_done && !(bus.gen_valid && !ready)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_occ == '0) begin
                    state_d = StDone;
                end
            end
            default: ;
        endcase
    end

    // State, counters and latched generator arguments.
    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            limit_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            if (start_run) begin
                base_q  <= arg0;
                limit_q <= arg1;
                step_q  <= arg2;
            end
        end
    end

    assign bus.gen_start = (state_q == StLaunch);
    assign bus.gen_base  = base_q;
    assign bus.gen_limit = limit_q;
    assign bus.gen_step  = step_q;
    assign bus.gen_ready = ready;
    assign bus.m_valid   = !fifo_empty;
    assign bus.m_data0   = head[2*WIDTH-1:WIDTH];
    assign bus.m_data1   = head[WIDTH-1:0];

    assign busy        = (state_q == StLaunch) || (state_q == StCollect) || (state_q == StDrain);
    assign run_done    = (state_q == StDone);
    assign run_err     = (state_q == StError);
    assign tuple_count = cnt_q;

endmodule

// File: tb/tb_gen_stream_collector.sv
// Directed bench for gen_stream_collector with an hrange-style generator stub.
module tb_gen_stream_collector;
    import gen_collect_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               cmd_start;
    logic signed [31:0] arg0, arg1, arg2;
    logic               busy, run_done, run_err;
    logic [15:0]        tuple_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Stub behaviour: 0 = normal hrange, 1 = done with the last tuple, 2 = silent.
    int                 mode;
    logic               stub_active;
    logic signed [31:0] stub_cur, stub_lim, stub_stp;

    int     push_cnt;
    bit     mv_seen;
    bit     vd_push;
    tuple_t rx[$];

    gen_stream_collector_if #(.WIDTH(32)) bus ();

    gen_stream_collector #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TIMEOUT (16),
        .CNT_W   (16)
    ) dut (
        ._clock      (clk),
        ._reset      (rst_n),
        .cmd_start   (cmd_start),
        .arg0        (arg0),
        .arg1        (arg1),
        .arg2        (arg2),
        .bus         (bus),
        .busy        (busy),
        .run_done    (run_done),
        .run_err     (run_err),
        .tuple_count (tuple_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator stub: latches arguments on gen_start, steps on each handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_active <= 1'b0;
            stub_cur    <= '0;
            stub_lim    <= '0;
            stub_stp    <= '0;
        end else if (bus.gen_start) begin
            stub_active <= 1'b1;
            stub_cur    <= bus.gen_base;
            stub_lim    <= bus.gen_limit;
            stub_stp    <= bus.gen_step;
        end else if (bus.gen_valid && bus.gen_ready) begin
            stub_cur <= stub_cur + stub_stp;
        end
    end

    assign bus.gen_valid = stub_active && (mode != 2) && (stub_cur < stub_lim);
    assign bus.gen_done  = stub_active &&
                           (((mode == 0) && (stub_cur >= stub_lim)) ||
                            ((mode == 1) && (stub_cur + stub_stp >= stub_lim)));
    assign bus.gen_out0  = stub_cur;
    assign bus.gen_out1  = stub_cur;

    // Monitor handshakes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gen_valid && bus.gen_ready) begin
                push_cnt++;
                if (bus.gen_done) vd_push = 1'b1;
            end
            if (bus.m_valid) mv_seen = 1'b1;
            if (bus.m_valid && bus.m_ready) begin
                tuple_t t;
                t.data0 = bus.m_data0;
                t.data1 = bus.m_data1;
                rx.push_back(t);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rx.delete();
        push_cnt = 0;
        mv_seen  = 1'b0;
        vd_push  = 1'b0;
    endtask

    task automatic launch(input int a0, input int a1, input int a2);
        arg0      = a0;
        arg1      = a1;
        arg2      = a2;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        while (!run_done && !run_err && n < max) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, run_done, 1);
    endtask

    task automatic check_stream(input string tag, input int base, input int step, input int cnt);
        check_eq({tag, "_len"}, rx.size(), cnt);
        for (int i = 0; i < rx.size() && i < cnt; i++) begin
            check_eq($sformatf("%s_d0_%0d", tag, i), rx[i].data0, base + i * step);
            check_eq($sformatf("%s_d1_%0d", tag, i), rx[i].data1, base + i * step);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n       = 1'b1;
        cmd_start   = 1'b0;
        arg0        = '0;
        arg1        = '0;
        arg2        = '0;
        mode        = 0;
        bus.m_ready = 1'b0;
        clear_mon();
        #2 rst_n = 1'b0;
        #10;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", run_done, 0);
        check_eq("rst_err", run_err, 0);
        check_eq("rst_start", bus.gen_start, 0);
        check_eq("rst_ready", bus.gen_ready, 0);
        check_eq("rst_mvalid", bus.m_valid, 0);
        check_eq("rst_count", tuple_count, 0);
        check_eq("rst_base", bus.gen_base, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic range (1,11,3) with a free-running sink.
        bus.m_ready = 1'b1;
        clear_mon();
        launch(1, 11, 3);
        check_eq("t1_start", bus.gen_start, 1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_base", bus.gen_base, 1);
        check_eq("t1_limit", bus.gen_limit, 11);
        check_eq("t1_step", bus.gen_step, 3);
        tick();
        check_eq("t1_start_low", bus.gen_start, 0);
        check_eq("t1_ready", bus.gen_ready, 1);
        check_eq("t1_mvalid0", bus.m_valid, 0);
        tick();
        check_eq("t1_mvalid1", bus.m_valid, 1);
        check_eq("t1_head", bus.m_data0, 1);
        wait_done("t1", 100, n);
        check_stream("t1", 1, 3, 4);
        check_eq("t1_count", tuple_count, 4);
        check_eq("t1_busy_end", busy, 0);

        // Empty range: straight through DRAIN, nothing pushed.
        clear_mon();
        launch(5, 5, 1);
        wait_done("t2", 20, n);
        check_eq("t2_latency_le3", n <= 3, 1);
        check_eq("t2_count", tuple_count, 0);
        check_eq("t2_mvalid_seen", mv_seen, 0);
        check_eq("t2_pushes", push_cnt, 0);

        // Backpressure: FIFO of 4 fills, generator stalls, then everything drains.
        bus.m_ready = 1'b0;
        clear_mon();
        launch(0, 20, 2);
        for (int i = 0; i < 30; i++) tick();
        check_eq("t3_ready_low", bus.gen_ready, 0);
        check_eq("t3_held", push_cnt, 4);
        check_eq("t3_count_held", tuple_count, 4);
        check_eq("t3_mvalid", bus.m_valid, 1);
        check_eq("t3_head", bus.m_data0, 0);
        check_eq("t3_busy", busy, 1);
        // A start request while busy must not disturb the run.
        arg0      = 77;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check_eq("t3_ign_start", bus.gen_start, 0);
        check_eq("t3_ign_base", bus.gen_base, 0);
        bus.m_ready = 1'b1;
        wait_done("t3", 200, n);
        check_stream("t3", 0, 2, 10);
        check_eq("t3_count", tuple_count, 10);

        // Last tuple arrives together with done.
        mode = 1;
        clear_mon();
        launch(0, 10, 2);
        n = 0;
        begin
            bit drain_seen = 1'b0;
            while (!run_done && !run_err && n < 100) begin
                tick();
                n++;
                if (busy && !bus.gen_ready && !bus.gen_start) drain_seen = 1'b1;
            end
            check_eq("t4_drain_seen", drain_seen, 1);
        end
        check_eq("t4_done", run_done, 1);
        check_eq("t4_vd_push", vd_push, 1);
        check_eq("t4_count", tuple_count, 5);
        check_stream("t4", 0, 2, 5);

        // Silent generator: timeout after exactly 16 COLLECT cycles.
        mode = 2;
        clear_mon();
        launch(1, 2, 3);
        check_eq("t5_start", bus.gen_start, 1);
        for (int i = 0; i < 16; i++) tick();
        check_eq("t5_err_early", run_err, 0);
        check_eq("t5_busy_16", busy, 1);
        tick();
        check_eq("t5_err", run_err, 1);
        check_eq("t5_ready", bus.gen_ready, 0);
        check_eq("t5_busy", busy, 0);
        mode = 0;
        clear_mon();
        launch(1, 11, 3);
        check_eq("t5_err_clr", run_err, 0);
        wait_done("t5r", 100, n);
        check_eq("t5r_count", tuple_count, 4);
        check_stream("t5r", 1, 3, 4);

        // Reset in the middle of a run.
        bus.m_ready = 1'b0;
        clear_mon();
        launch(1, 5, 1);
        n = 0;
        while (push_cnt < 2 && n < 50) begin
            tick();
            n++;
        end
        check_eq("t6_pre_push", push_cnt, 2);
        rst_n = 1'b0;
        #1;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_mvalid", bus.m_valid, 0);
        check_eq("t6_ready", bus.gen_ready, 0);
        check_eq("t6_start", bus.gen_start, 0);
        check_eq("t6_count", tuple_count, 0);
        check_eq("t6_base", bus.gen_base, 0);
        check_eq("t6_done", run_done, 0);
        check_eq("t6_err", run_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_empty", bus.m_valid, 0);
        bus.m_ready = 1'b1;
        clear_mon();
        launch(1, 5, 1);
        wait_done("t6r", 100, n);
        check_stream("t6r", 1, 1, 4);
        check_eq("t6r_count", tuple_count, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
